pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central hazard/stall/flush controller for the 5-stage RISC-V core. It drives the hold and flush inputs of the PC, IF/ID and ID/EX pipeline registers. It arbitrates between branch/jump redirects from EX, load-use hazards, multi-cycle EX operations (divider) and external bus-hold requests. It buffers a redirect that collides with a bus hold, and counts stall cycles for performance monitoring.

Parameters:
MC_TIMEOUT, 64, max cycles in MC_WAIT before forced abort (>=2)
CNT_W, 32, width of stall cycle counter

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
jump_en_i  in  1  EX requests PC redirect (taken branch/jal/jalr)
jump_addr_i  in  32  redirect target
ex_load_i  in  1  instruction in EX is a load
ex_reg_wen_i  in  1  EX instruction writes rd
ex_rd_addr_i  in  5  EX destination register
id_rs1_ren_i  in  1  ID instruction reads rs1
id_rs1_addr_i  in  5  ID rs1 index
id_rs2_ren_i  in  1  ID instruction reads rs2
id_rs2_addr_i  in  5  ID rs2 index
mc_start_i  in  1  EX launches a multi-cycle op (one-cycle pulse)
mc_done_i  in  1  multi-cycle result valid (one-cycle pulse)
hold_req_i  in  1  external bus master requests a full pipeline freeze
pc_hold_o  out  1  PC keeps its value
if_id_hold_o  out  1  IF/ID keeps contents
if_id_flush_o  out  1  IF/ID loads NOP
id_ex_hold_o  out  1  ID/EX keeps contents
id_ex_flush_o  out  1  ID/EX loads NOP, reg_wen=0
jump_en_o  out  1  PC loads jump_addr_o
jump_addr_o  out  32  redirect target to PC
mc_timeout_o  out  1  one-cycle pulse on multi-cycle abort
stall_cnt_o  out  CNT_W  cycles with pc_hold_o=1, saturating

Behaviour:
- State regs: state {RUN, MC_WAIT}; mc_cnt (clog2(MC_TIMEOUT) bits); pend_vld, pend_addr[31:0]; stall_cnt.
- Control outputs are combinational from current state and inputs (0-cycle latency). They take effect at the same edge the pipeline registers capture. mc_timeout_o and stall_cnt_o are registered.
- While rst=1: holds=0, if_id_flush_o=id_ex_flush_o=1, jump_en_o=0, jump_addr_o=0. Next state RUN, mc_cnt=0, pend_vld=0, pend_addr=0, stall_cnt=0, mc_timeout_o=0. Reset mid-MC_WAIT or with a pending jump discards both.
- Load-use hazard LU = ex_load_i & ex_reg_wen_i & ex_rd_addr_i!=0 & ((id_rs1_ren_i & rs1==rd) | (id_rs2_ren_i & rs2==rd)).
- RUN priority (highest first):
  1. pend_vld & !hold_req_i: jump_en_o=1, jump_addr_o=pend_addr, if_id_flush=id_ex_flush=1; pend_vld<=0.
  2. jump_en_i & hold_req_i: pc_hold=1, if_id_flush=id_ex_flush=1; pend_vld<=1, pend_addr<=jump_addr_i.
  3. jump_en_i: jump_en_o=1, jump_addr_o=jump_addr_i, if_id_flush=id_ex_flush=1. LU is ignored because the ID instruction is squashed.
  4. hold_req_i: pc_hold=if_id_hold=id_ex_hold=1. Held pend_vld stays set.
  5. mc_start_i: pc_hold=if_id_hold=id_ex_hold=1; state<=MC_WAIT, mc_cnt<=0.
  6. LU: pc_hold=if_id_hold=1, id_ex_flush=1 (one bubble).
  7. Otherwise all outputs 0.
- Outputs not named in the selected case are 0. jump_addr_o=0 when jump_en_o=0.
- MC_WAIT:
  - pc_hold=if_id_hold=id_ex_hold=1 unconditionally. jump_en_i and mc_start_i are ignored (protocol violation; assertion in bench). hold_req_i is absorbed.
  - mc_done_i: holds deasserted in that same cycle; state<=RUN.
  - Else if mc_cnt==MC_TIMEOUT-1: holds deasserted, id_ex_flush=1; mc_timeout_o<=1 for one cycle; state<=RUN.
  - Else mc_cnt<=mc_cnt+1.
  - mc_done_i and timeout in the same cycle: done wins, no timeout pulse.
- stall_cnt increments each cycle pc_hold_o=1 and saturates at all-ones.
- Hold and flush are never both 1 for the same register.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> flushes=1, holds=0, stall_cnt_o=0. After rst=0 with no inputs -> all control outputs 0.
- Load-use: ex_load=1, ex_reg_wen=1, ex_rd=5, id_rs2_ren=1, rs2=5 for one cycle -> pc_hold=if_id_hold=id_ex_flush=1 that cycle, stall_cnt_o=1 next cycle. Same stimulus with ex_rd=0 -> no stall.
- Jump: jump_en_i=1, addr=0x0000_0100, also LU true -> jump_en_o=1, jump_addr_o=0x100, both flushes=1, no holds.
- Jump under bus hold: hold_req=1 for 3 cycles with jump_en_i=1 (addr 0x200) in the first cycle -> that cycle flushes=1, pc_hold=1, jump_en_o=0. Full holds for the next 2 cycles. In the first cycle after hold_req drops -> jump_en_o=1, jump_addr_o=0x200.
- Divider: mc_start pulse, mc_done 5 cycles later -> holds=1 for 5 cycles, 0 in the done cycle, state RUN, mc_timeout_o=0.
- Timeout with MC_TIMEOUT=4 and no mc_done: holds for 4 cycles (start cycle plus 3), then id_ex_flush=1 in the 4th MC_WAIT cycle and mc_timeout_o=1 next cycle. Reset asserted mid-MC_WAIT -> RUN, holds drop, no timeout pulse.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Hazard, stall and flush controller for the 5-stage core: arbitrates redirects,
// load-use bubbles, multi-cycle EX waits and bus-hold freezes, and counts stall cycles.
module pipe_ctrl #(
    parameter int unsigned MC_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump_en_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             ex_load_i,
    input  logic             ex_reg_wen_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             id_rs1_ren_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic             id_rs2_ren_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             mc_start_i,
    input  logic             mc_done_i,
    input  logic             hold_req_i,
    output logic             pc_hold_o,
    output logic             if_id_hold_o,
    output logic             if_id_flush_o,
    output logic             id_ex_hold_o,
    output logic             id_ex_flush_o,
    output logic             jump_en_o,
    output logic [31:0]      jump_addr_o,
    output logic             mc_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned MC_W = $clog2(MC_TIMEOUT);
    localparam logic [MC_W-1:0] MC_LAST = MC_W'(MC_TIMEOUT - 1);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MC_WAIT = 1'b1;

    logic [0:0]      state, state_nxt;
    logic [MC_W-1:0] mc_cnt, mc_cnt_nxt;
    logic            pend_vld, pend_vld_nxt;
    logic [31:0]     pend_addr, pend_addr_nxt;
    logic            timeout_fire;
    logic            load_use;

    assign load_use = ex_load_i && ex_reg_wen_i && (ex_rd_addr_i != 5'd0) &&
                      ((id_rs1_ren_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                       (id_rs2_ren_i && (id_rs2_addr_i == ex_rd_addr_i)));

    always_comb begin
        pc_hold_o     = 1'b0;
        if_id_hold_o  = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_hold_o  = 1'b0;
        id_ex_flush_o = 1'b0;
        jump_en_o     = 1'b0;
        jump_addr_o   = '0;
        state_nxt     = state;
        mc_cnt_nxt    = mc_cnt;
        pend_vld_nxt  = pend_vld;
        pend_addr_nxt = pend_addr;
        timeout_fire  = 1'b0;

        if (rst) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (state == ST_RUN) begin
            if (pend_vld && !hold_req_i) begin
                jump_en_o     = 1'b1;
                jump_addr_o   = pend_addr;
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
                pend_vld_nxt  = 1'b0;
            end else if (jump_en_i && hold_req_i) begin
                // PC cannot take the redirect while frozen; park it until the hold drops
                pc_hold_o     = 1'b1;
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
                pend_vld_nxt  = 1'b1;
                pend_addr_nxt = jump_addr_i;
            end else if (jump_en_i) begin
                jump_en_o     = 1'b1;
                jump_addr_o   = jump_addr_i;
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end else if (hold_req_i) begin
                pc_hold_o    = 1'b1;
                if_id_hold_o = 1'b1;
                id_ex_hold_o = 1'b1;
            end else if (mc_start_i) begin
                pc_hold_o    = 1'b1;
                if_id_hold_o = 1'b1;
                id_ex_hold_o = 1'b1;
                state_nxt    = ST_MC_WAIT;
                mc_cnt_nxt   = '0;
            end else if (load_use) begin
                pc_hold_o     = 1'b1;
                if_id_hold_o  = 1'b1;
                id_ex_flush_o = 1'b1;
            end
        end else begin
            // Completion beats a coincident timeout
            if (mc_done_i) begin
                state_nxt = ST_RUN;
            end else if (mc_cnt == MC_LAST) begin
                id_ex_flush_o = 1'b1;
                timeout_fire  = 1'b1;
                state_nxt     = ST_RUN;
            end else begin
                pc_hold_o    = 1'b1;
                if_id_hold_o = 1'b1;
                id_ex_hold_o = 1'b1;
                mc_cnt_nxt   = mc_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            mc_cnt       <= '0;
            pend_vld     <= 1'b0;
            pend_addr    <= '0;
            mc_timeout_o <= 1'b0;
            stall_cnt_o  <= '0;
        end else begin
            state        <= state_nxt;
            mc_cnt       <= mc_cnt_nxt;
            pend_vld     <= pend_vld_nxt;
            pend_addr    <= pend_addr_nxt;
            mc_timeout_o <= timeout_fire;
            if (pc_hold_o && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a default instance plus a short-timeout, narrow-counter
// instance driven by the same stimulus.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        ex_load_i, ex_reg_wen_i;
    logic [4:0]  ex_rd_addr_i;
    logic        id_rs1_ren_i, id_rs2_ren_i;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i;
    logic        mc_start_i, mc_done_i, hold_req_i;

    logic        pc_hold_a, if_id_hold_a, if_id_flush_a, id_ex_hold_a, id_ex_flush_a, jump_en_a;
    logic [31:0] jump_addr_a;
    logic        tmo_a;
    logic [31:0] stall_a;
    logic        pc_hold_b, if_id_hold_b, if_id_flush_b, id_ex_hold_b, id_ex_flush_b, jump_en_b;
    logic [31:0] jump_addr_b;
    logic        tmo_b;
    logic [3:0]  stall_b;

    logic [5:0]  ctl_a, ctl_b;
    assign ctl_a = {pc_hold_a, if_id_hold_a, if_id_flush_a, id_ex_hold_a, id_ex_flush_a, jump_en_a};
    assign ctl_b = {pc_hold_b, if_id_hold_b, if_id_flush_b, id_ex_hold_b, id_ex_flush_b, jump_en_b};

    // {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, jump_en}
    localparam logic [5:0] C_IDLE   = 6'b000000;
    localparam logic [5:0] C_RST    = 6'b001010;
    localparam logic [5:0] C_LU     = 6'b110010;
    localparam logic [5:0] C_JMP    = 6'b001011;
    localparam logic [5:0] C_JHOLD  = 6'b101010;
    localparam logic [5:0] C_FREEZE = 6'b110100;
    localparam logic [5:0] C_TMO    = 6'b000010;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    pipe_ctrl u_a (
        .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .ex_load_i(ex_load_i), .ex_reg_wen_i(ex_reg_wen_i), .ex_rd_addr_i(ex_rd_addr_i),
        .id_rs1_ren_i(id_rs1_ren_i), .id_rs1_addr_i(id_rs1_addr_i),
        .id_rs2_ren_i(id_rs2_ren_i), .id_rs2_addr_i(id_rs2_addr_i),
        .mc_start_i(mc_start_i), .mc_done_i(mc_done_i), .hold_req_i(hold_req_i),
        .pc_hold_o(pc_hold_a), .if_id_hold_o(if_id_hold_a), .if_id_flush_o(if_id_flush_a),
        .id_ex_hold_o(id_ex_hold_a), .id_ex_flush_o(id_ex_flush_a),
        .jump_en_o(jump_en_a), .jump_addr_o(jump_addr_a),
        .mc_timeout_o(tmo_a), .stall_cnt_o(stall_a)
    );

    pipe_ctrl #(.MC_TIMEOUT(4), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .ex_load_i(ex_load_i), .ex_reg_wen_i(ex_reg_wen_i), .ex_rd_addr_i(ex_rd_addr_i),
        .id_rs1_ren_i(id_rs1_ren_i), .id_rs1_addr_i(id_rs1_addr_i),
        .id_rs2_ren_i(id_rs2_ren_i), .id_rs2_addr_i(id_rs2_addr_i),
        .mc_start_i(mc_start_i), .mc_done_i(mc_done_i), .hold_req_i(hold_req_i),
        .pc_hold_o(pc_hold_b), .if_id_hold_o(if_id_hold_b), .if_id_flush_o(if_id_flush_b),
        .id_ex_hold_o(id_ex_hold_b), .id_ex_flush_o(id_ex_flush_b),
        .jump_en_o(jump_en_b), .jump_addr_o(jump_addr_b),
        .mc_timeout_o(tmo_b), .stall_cnt_o(stall_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge; inputs change here, checks follow #3 later
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        jump_en_i = 1'b0; jump_addr_i = '0;
        ex_load_i = 1'b0; ex_reg_wen_i = 1'b0; ex_rd_addr_i = '0;
        id_rs1_ren_i = 1'b0; id_rs1_addr_i = '0;
        id_rs2_ren_i = 1'b0; id_rs2_addr_i = '0;
        mc_start_i = 1'b0; mc_done_i = 1'b0; hold_req_i = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic r1en, input logic [4:0] r1,
                          input logic r2en, input logic [4:0] r2);
        ex_load_i = 1'b1; ex_reg_wen_i = 1'b1; ex_rd_addr_i = rd;
        id_rs1_ren_i = r1en; id_rs1_addr_i = r1;
        id_rs2_ren_i = r2en; id_rs2_addr_i = r2;
    endtask

    initial begin
        idle();
        rst = 1'b1;

        // Reset: flushes only, counters clear
        for (int i = 0; i < 2; i++) begin
            cyc(); #3;
            check("rst_ctl", 32'(ctl_a), 32'(C_RST));
            check("rst_addr", jump_addr_a, 32'h0);
            check("rst_stall", stall_a, 32'd0);
            check("rst_tmo", 32'(tmo_a), 32'd0);
        end
        cyc(); rst = 1'b0; #3;
        check("idle_ctl", 32'(ctl_a), 32'(C_IDLE));

        // Load-use via rs2, then rd=x0, then via rs1, then rs1 match without read enable
        cyc(); set_lu(5'd5, 1'b0, 5'd0, 1'b1, 5'd5); #3;
        check("lu_rs2_ctl", 32'(ctl_a), 32'(C_LU));
        cyc(); set_lu(5'd0, 1'b0, 5'd0, 1'b1, 5'd0); #3;
        check("lu_x0_ctl", 32'(ctl_a), 32'(C_IDLE));
        check("lu_stall1", stall_a, 32'd1);
        cyc(); set_lu(5'd9, 1'b1, 5'd9, 1'b0, 5'd0); #3;
        check("lu_rs1_ctl", 32'(ctl_a), 32'(C_LU));
        cyc(); set_lu(5'd9, 1'b0, 5'd9, 1'b1, 5'd3); #3;
        check("lu_noren_ctl", 32'(ctl_a), 32'(C_IDLE));
        check("lu_stall2", stall_a, 32'd2);

        // Jump with a simultaneous load-use: redirect wins, no holds
        cyc(); set_lu(5'd5, 1'b0, 5'd0, 1'b1, 5'd5); jump_en_i = 1'b1; jump_addr_i = 32'h100; #3;
        check("jmp_ctl", 32'(ctl_a), 32'(C_JMP));
        check("jmp_addr", jump_addr_a, 32'h100);

        // Jump colliding with bus hold is buffered until the hold drops
        cyc(); idle(); hold_req_i = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'h200; #3;
        check("jh_ctl", 32'(ctl_a), 32'(C_JHOLD));
        check("jh_addr", jump_addr_a, 32'h0);
        for (int i = 0; i < 2; i++) begin
            cyc(); jump_en_i = 1'b0; jump_addr_i = '0; #3;
            check("jh_freeze_ctl", 32'(ctl_a), 32'(C_FREEZE));
        end
        cyc(); hold_req_i = 1'b0; #3;
        check("jh_rel_ctl", 32'(ctl_a), 32'(C_JMP));
        check("jh_rel_addr", jump_addr_a, 32'h200);
        check("jh_stall", stall_a, 32'd5);
        cyc(); #3;
        check("jh_after_ctl", 32'(ctl_a), 32'(C_IDLE));

        // Divider: done 5 cycles after start on u_a; u_b times out at its 4th wait cycle
        cyc(); mc_start_i = 1'b1; #3;
        check("mc_start_ctl", 32'(ctl_a), 32'(C_FREEZE));
        for (int i = 1; i <= 4; i++) begin
            cyc(); mc_start_i = 1'b0; #3;
            check("mc_wait_ctl_a", 32'(ctl_a), 32'(C_FREEZE));
            check("mc_wait_ctl_b", 32'(ctl_b), (i == 4) ? 32'(C_TMO) : 32'(C_FREEZE));
        end
        cyc(); mc_done_i = 1'b1; #3;
        check("mc_done_ctl_a", 32'(ctl_a), 32'(C_IDLE));
        check("mc_done_ctl_b", 32'(ctl_b), 32'(C_IDLE));
        check("tmo_pulse_b", 32'(tmo_b), 32'd1);
        check("tmo_stall_b", 32'(stall_b), 32'd9);
        cyc(); mc_done_i = 1'b0; #3;
        check("mc_after_ctl_a", 32'(ctl_a), 32'(C_IDLE));
        check("mc_tmo_a", 32'(tmo_a), 32'd0);
        check("tmo_drop_b", 32'(tmo_b), 32'd0);
        check("mc_stall_a", stall_a, 32'd10);

        // Done coincides with the timeout cycle on u_b: done wins, no pulse
        cyc(); mc_start_i = 1'b1; #3;
        for (int i = 1; i <= 3; i++) begin
            cyc(); mc_start_i = 1'b0; #3;
        end
        cyc(); mc_done_i = 1'b1; #3;
        check("tie_ctl_b", 32'(ctl_b), 32'(C_IDLE));
        check("tie_ctl_a", 32'(ctl_a), 32'(C_IDLE));
        cyc(); mc_done_i = 1'b0; #3;
        check("tie_tmo_b", 32'(tmo_b), 32'd0);
        check("tie_run_a", 32'(ctl_a), 32'(C_IDLE));

        // Reset in the middle of MC_WAIT abandons the wait without a timeout pulse
        cyc(); mc_start_i = 1'b1; #3;
        for (int i = 0; i < 2; i++) begin
            cyc(); mc_start_i = 1'b0; #3;
        end
        cyc(); rst = 1'b1; #3;
        check("mcrst_ctl_b", 32'(ctl_b), 32'(C_RST));
        cyc(); rst = 1'b0; #3;
        check("mcrst_run_a", 32'(ctl_a), 32'(C_IDLE));
        check("mcrst_run_b", 32'(ctl_b), 32'(C_IDLE));
        check("mcrst_stall", stall_a, 32'd0);
        cyc(); #3;
        check("mcrst_tmo_b", 32'(tmo_b), 32'd0);

        // Reset discards a buffered redirect
        cyc(); hold_req_i = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'h300; #3;
        cyc(); idle(); rst = 1'b1; #3;
        cyc(); rst = 1'b0; #3;
        check("pend_rst_ctl", 32'(ctl_a), 32'(C_IDLE));
        check("pend_rst_addr", jump_addr_a, 32'h0);

        // Stall counter saturation on the 4-bit instance
        cyc(); hold_req_i = 1'b1; #3;
        for (int i = 1; i < 20; i++) begin
            cyc(); #3;
        end
        cyc(); hold_req_i = 1'b0; #3;
        check("sat_stall_a", stall_a, 32'd20);
        check("sat_stall_b", 32'(stall_b), 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
